// File: rtl/conv_pkg.sv
// Shared constants, array types and sequencer state encoding for the 3x3 conv engine front/back end.
package conv_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RES_W     = 16;
  localparam int unsigned TILE_DIM  = 6;
  localparam int unsigned KER_DIM   = 3;
  localparam int unsigned OUT_DIM   = TILE_DIM - 2;
  localparam int unsigned KER_BEATS = KER_DIM * KER_DIM;
  localparam int unsigned N_BEATS   = KER_BEATS + TILE_DIM * TILE_DIM;
  localparam int unsigned N_WORDS   = OUT_DIM * OUT_DIM;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [RES_W-1:0]  res_t;

  typedef data_t [0:TILE_DIM-1][0:TILE_DIM-1] tile_t;
  typedef data_t [0:KER_DIM-1][0:KER_DIM-1]   kernel_t;
  typedef res_t  [0:OUT_DIM-1][0:OUT_DIM-1]   result_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2,
    ARM   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/conv_result_serializer.sv
// Latches a 4x4 result array on a load strobe and streams it out row-major
// as 16 valid/ready words, flagging the final word with last.
module conv_result_serializer
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  result_t          res_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [RES_W-1:0] data_o,
  output logic             last_o,
  output logic             done_o
);

  result_t          res_q, res_d;
  logic [3:0]       word_q, word_d;
  logic [3:0]       nxt_s;
  logic             valid_q, valid_d;
  logic [RES_W-1:0] data_q, data_d;
  logic             last_q, last_d;

  // Next word selection: load starts at c[0][0]; each handshake advances, word 15 ends the stream.
  always_comb begin
    res_d   = res_q;
    word_d  = word_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    nxt_s   = word_q + 4'd1;
    if (load_i) begin
      res_d   = res_i;
      word_d  = 4'd0;
      valid_d = 1'b1;
      data_d  = res_i[0][0];
      last_d  = 1'b0;
    end else if (valid_q && ready_i) begin
      if (word_q == 4'd15) begin
        word_d  = 4'd0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        word_d  = nxt_s;
        data_d  = res_q[nxt_s[3:2]][nxt_s[1:0]];
        last_d  = (nxt_s == 4'd15);
      end
    end else begin
      // stalled or idle: hold word, data and last
      word_d = word_q;
    end
  end

  // Result buffer and output stream registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign done_o  = valid_q & ready_i & last_q;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Loads a 3x3 kernel and 6x6 tile from a byte stream, runs the conv engine,
// then streams its 4x4 result out; re-arms the engine after every frame.
module conv_tile_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output tile_t             tile_o,
  output kernel_t           kernel_o,
  output logic              eng_start,
  input  logic              eng_done,
  input  result_t           eng_res,
  output logic              eng_arm_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [5:0]  LAST_BEAT = 6'(N_BEATS - 1);
  localparam logic [5:0]  KER_END   = 6'(KER_BEATS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [5:0]       beat_q, beat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             arm_q, arm_d;
  kernel_t          kernel_q, kernel_d;
  tile_t            tile_q, tile_d;
  logic             eng_start_q, eng_start_d;
  logic             eng_arm_n_q, eng_arm_n_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic             ser_load_s;
  logic             ser_done_s;

  logic [1:0]       k_row_s, k_col_s;
  logic [5:0]       t_idx_s;
  logic [2:0]       t_row_s, t_col_s;

  // Map the current beat number to kernel / tile coordinates (row-major).
  always_comb begin
    k_row_s = 2'(beat_q / 6'd3);
    k_col_s = 2'(beat_q % 6'd3);
    t_idx_s = beat_q - KER_END;
    t_row_s = 3'(t_idx_s / 6'd6);
    t_col_s = 3'(t_idx_s % 6'd6);
  end

  // Sequencer next-state, array capture, engine handshake and error pulses.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    arm_d       = arm_q;
    kernel_d    = kernel_q;
    tile_d      = tile_q;
    eng_start_d = eng_start_q;
    eng_arm_n_d = 1'b1;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    ser_load_s  = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (beat_q == LAST_BEAT) begin
            // final beat: missing in_last is flagged but the frame still runs
            tile_d[t_row_s][t_col_s] = in_data;
            err_len_d   = ~in_last;
            beat_d      = 6'd0;
            tmo_d       = '0;
            eng_start_d = 1'b1;
            state_d     = START;
          end else if (in_last) begin
            // short frame: drop this beat and restart; earlier entries stay as written
            err_len_d = 1'b1;
            beat_d    = 6'd0;
          end else begin
            if (beat_q < KER_END) begin
              kernel_d[k_row_s][k_col_s] = in_data;
            end else begin
              tile_d[t_row_s][t_col_s] = in_data;
            end
            beat_d = beat_q + 6'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      START: begin
        if (eng_done) begin
          ser_load_s  = 1'b1;
          eng_start_d = 1'b0;
          state_d     = DRAIN;
        end else if (tmo_q == TMO_LAST) begin
          err_tmo_d   = 1'b1;
          eng_start_d = 1'b0;
          arm_d       = 1'b0;
          eng_arm_n_d = 1'b0;
          state_d     = ARM;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DRAIN: begin
        if (ser_done_s) begin
          arm_d       = 1'b0;
          eng_arm_n_d = 1'b0;
          state_d     = ARM;
        end else begin
          state_d = DRAIN;
        end
      end
      ARM: begin
        if (arm_q) begin
          arm_d       = 1'b0;
          eng_arm_n_d = 1'b1;
          state_d     = LOAD;
        end else begin
          arm_d       = 1'b1;
          eng_arm_n_d = 1'b0;
        end
      end
      default: begin
        state_d     = LOAD;
        beat_d      = 6'd0;
        eng_start_d = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters, captured arrays and engine/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      beat_q      <= 6'd0;
      tmo_q       <= '0;
      arm_q       <= 1'b0;
      kernel_q    <= '0;
      tile_q      <= '0;
      eng_start_q <= 1'b0;
      eng_arm_n_q <= 1'b1;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      arm_q       <= arm_d;
      kernel_q    <= kernel_d;
      tile_q      <= tile_d;
      eng_start_q <= eng_start_d;
      eng_arm_n_q <= eng_arm_n_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  conv_result_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load_s),
    .res_i   (eng_res),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .last_o  (out_last),
    .done_o  (ser_done_s)
  );

  assign in_ready    = (state_q == LOAD);
  assign busy        = ~((state_q == LOAD) && (beat_q == 6'd0));
  assign tile_o      = tile_q;
  assign kernel_o    = kernel_q;
  assign eng_start   = eng_start_q;
  assign eng_arm_n   = eng_arm_n_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer with a behavioural conv engine stub.
module tb_conv_tile_sequencer;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  tile_t             tile_o;
  kernel_t           kernel_o;
  logic              eng_start;
  logic              eng_done = 1'b0;
  result_t           eng_res = '0;
  logic              eng_arm_n;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RES_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              err_len;
  logic              err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [7:0] ker_b [9];
  logic signed [7:0] tile_b [36];
  logic [15:0]       exp_w [16];
  bit                eng_en   = 1'b1;
  bit                res_mode = 1'b0;
  int                eng_cnt  = 0;

  always #5 clk = ~clk;

  conv_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .tile_o(tile_o), .kernel_o(kernel_o),
    .eng_start(eng_start), .eng_done(eng_done), .eng_res(eng_res),
    .eng_arm_n(eng_arm_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pattern_word(input int i);
    if (i == 0) return 16'h8000;
    else if (i == 15) return 16'h7FFF;
    else return 16'(i * 273);
  endfunction

  // Engine stub: 3x3 valid convolution of whatever the DUT presents.
  function automatic result_t engine_model(input tile_t t, input kernel_t k);
    result_t r;
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            s += int'($signed(t[i+a][j+b])) * int'($signed(k[a][b]));
        r[i][j] = res_mode ? pattern_word(i*4+j) : s[15:0];
      end
    return r;
  endfunction

  // Engine stub timing: done 20 cycles into eng_start, held until start drops.
  always @(posedge clk) begin
    if (eng_start !== 1'b1) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 19 && eng_en) begin
        eng_done <= 1'b1;
        eng_res  <= engine_model(tile_o, kernel_o);
      end
    end
  end

  task automatic set_frame(input int mode);
    for (int k = 0; k < 9; k++)
      ker_b[k] = (mode == 0) ? 8'sd1 : (mode == 1) ? 8'(k - 4) : -8'sd128;
    for (int k = 0; k < 36; k++)
      tile_b[k] = (mode == 0) ? 8'(k) : (mode == 1) ? 8'((k * 7) % 23 - 11) : 8'(k - 18);
  endtask

  task automatic build_exp();
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int a = 0; a < 3; a++)
          for (int b = 0; b < 3; b++)
            s += int'(tile_b[(i+a)*6 + j+b]) * int'(ker_b[a*3+b]);
        exp_w[i*4+j] = res_mode ? pattern_word(i*4+j) : s[15:0];
      end
  endtask

  // Drives n beats back to back from the #1-after-edge point; in_last on the final one.
  task automatic send_beats(input int n);
    check_eq("in_ready_frame_start", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = (k < 9) ? ker_b[k] : tile_b[k-9];
      in_last  = (k == n - 1);
      if (k == 44) check_eq("eng_start_pre", {31'd0, eng_start}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_arrays();
    for (int k = 0; k < 9; k++)
      check_eq("kernel_o", {24'd0, kernel_o[k/3][k%3]}, {24'd0, ker_b[k]});
    for (int k = 0; k < 36; k++)
      check_eq("tile_o", {24'd0, tile_o[k/6][k%6]}, {24'd0, tile_b[k]});
  endtask

  task automatic drain_and_arm(input bit stall);
    int got = 0;
    int cyc = 0;
    int low = 0;
    bit held = 1'b0;
    logic [15:0] hold_d = '0;
    logic hold_l = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (got < 16 && cyc < 400) begin
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (held) begin
        check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("hold_data", {16'd0, out_data}, {16'd0, hold_d});
        check_eq("hold_last", {31'd0, out_last}, {31'd0, hold_l});
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        check_eq("word", {16'd0, out_data}, {16'd0, exp_w[got]});
        check_eq("last", {31'd0, out_last}, {31'd0, (got == 15)});
        got++;
      end else if (out_valid) begin
        held   = 1'b1;
        hold_d = out_data;
        hold_l = out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("words_total", got, 32'd16);
    out_ready = 1'b0;
    check_eq("valid_after_last", {31'd0, out_valid}, 32'd0);
    check_eq("arm_first", {31'd0, eng_arm_n}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (!eng_arm_n) low++;
      @(posedge clk); #1;
    end
    check_eq("arm_low_cycles", low, 32'd2);
    check_eq("in_ready_after_arm", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int got;
    bit seen_valid;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_arm_n", {31'd0, eng_arm_n}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_eng_start", {31'd0, eng_start}, 32'd0);
    check_eq("rst_err", {30'd0, err_len, err_timeout}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data}, 32'd0);

    // 1: kernel of ones, ramp tile, no backpressure
    set_frame(0); build_exp();
    check_eq("exp_c00", {16'd0, exp_w[0]}, 32'd63);
    check_eq("exp_c33", {16'd0, exp_w[15]}, 32'd252);
    send_beats(45);
    check_eq("eng_start_rise", {31'd0, eng_start}, 32'd1);
    check_eq("busy_start", {31'd0, busy}, 32'd1);
    check_eq("no_err_len", {31'd0, err_len}, 32'd0);
    check_arrays();
    drain_and_arm(1'b0);

    // 2: same frame with 1,0,0,1 backpressure
    send_beats(45);
    drain_and_arm(1'b1);

    // 3: early in_last on beat 10, then a clean frame
    set_frame(1); build_exp();
    send_beats(11);
    check_eq("err_len_pulse", {31'd0, err_len}, 32'd1);
    check_eq("err_len_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("err_len_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("err_len_single", {31'd0, err_len}, 32'd0);
    send_beats(45);
    check_arrays();
    drain_and_arm(1'b0);

    // 4: engine never finishes
    eng_en = 1'b0;
    send_beats(45);
    n = 0; seen_valid = 1'b0;
    while (!err_timeout && n < 1100) begin
      seen_valid |= out_valid;
      @(posedge clk); #1;
      n++;
    end
    check_eq("tmo_cycles", n, 32'd1024);
    check_eq("tmo_no_valid", {31'd0, seen_valid}, 32'd0);
    check_eq("tmo_eng_start", {31'd0, eng_start}, 32'd0);
    check_eq("tmo_arm0", {31'd0, eng_arm_n}, 32'd0);
    @(posedge clk); #1;
    check_eq("tmo_single", {31'd0, err_timeout}, 32'd0);
    check_eq("tmo_arm1", {31'd0, eng_arm_n}, 32'd0);
    @(posedge clk); #1;
    check_eq("tmo_arm_done", {31'd0, eng_arm_n}, 32'd1);
    check_eq("tmo_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("tmo_out_valid", {31'd0, out_valid}, 32'd0);
    eng_en = 1'b1;

    // 5: reset after five words drained
    set_frame(0); build_exp();
    send_beats(45);
    got = 0; n = 0; out_ready = 1'b1;
    while (got < 5 && n < 200) begin
      @(negedge clk);
      if (out_valid) got++;
      @(posedge clk); #1;
      n++;
    end
    check_eq("pre_rst_words", got, 32'd5);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_data", {16'd0, out_data}, 32'd0);
    check_eq("mid_rst_last", {31'd0, out_last}, 32'd0);
    check_eq("mid_rst_tile", {24'd0, tile_o[5][5]}, 32'd0);
    check_eq("mid_rst_kernel", {24'd0, kernel_o[0][0]}, 32'd0);
    check_eq("mid_rst_arm_n", {31'd0, eng_arm_n}, 32'd1);
    check_eq("mid_rst_start", {31'd0, eng_start}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_beats(45);
    drain_and_arm(1'b0);

    // 6: extreme values pass through bit-exact
    res_mode = 1'b1;
    set_frame(2); build_exp();
    send_beats(45);
    check_eq("kernel_m128", {24'd0, kernel_o[0][0]}, 32'h80);
    check_eq("exp_8000", {16'd0, exp_w[0]}, 32'h8000);
    check_eq("exp_7fff", {16'd0, exp_w[15]}, 32'h7FFF);
    drain_and_arm(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_tile_sequencer.md
Name: conv_tile_sequencer

Overview:
Front-end/back-end sequencer for the 3x3 convolution engine. Accepts a byte stream carrying one 3x3 kernel and one 6x6 input tile, and presents both as stable parallel arrays. It then starts the engine, waits for completion, latches the 4x4 result and serialises it onto a 16-bit output stream. Sits between the NPU DMA/stream fabric and the engine; one instance per engine.

Parameters:
DATA_W, 8, signed tile/kernel element width
RES_W, 16, signed result element width
TILE_DIM, 6, input tile edge; output edge = TILE_DIM-2
KER_DIM, 3, kernel edge
TIMEOUT, 1024, max cycles waiting for eng_done before abort

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  DATA_W  signed byte; kernel first (9, row-major), then tile (36, row-major)
in_last  in  1  marks beat 45 of a frame
tile_o  out  [0:5][0:5] x DATA_W  tile to engine, signed
kernel_o  out  [0:2][0:2] x DATA_W  kernel to engine, signed
eng_start  out  1  engine start level
eng_done  in  1  engine completion level
eng_res  in  [0:3][0:3] x RES_W  engine result array
eng_arm_n  out  1  engine re-arm, active-low, 2-cycle pulse
out_valid  out  1  result word valid
out_ready  in  1  downstream accept
out_data  out  RES_W  result word, row-major c[r][col]
out_last  out  1  high with word 16
busy  out  1  frame in progress
err_len  out  1  one-cycle pulse, framing error
err_timeout  out  1  one-cycle pulse, engine timeout

Behaviour:
- States: LOAD, START, DRAIN, ARM. Beat counter 0..44, word counter 0..15, timeout counter, arm counter 0..1.
- Reset (async): state LOAD, all counters 0, tile_o/kernel_o all 0, eng_start 0, eng_arm_n 1, out_valid 0, out_data 0, out_last 0, err_* 0. in_ready=1 on the first clock after rst_n deasserts.
- in_ready = (state==LOAD), combinational from state. out_valid, out_data and out_last are registered.
- LOAD:
  - Beat k<9 writes kernel_o[k/3][k%3]; beat 9≤k<45 writes tile_o[(k-9)/6][(k-9)%6].
  - in_last on a beat k<44: err_len pulses next cycle, counter resets to 0, beat discarded, stay in LOAD. Previously written array entries are not cleared.
  - Beat 44 accepted: go to START. Missing in_last on beat 44 pulses err_len but the frame proceeds.
- START:
  - eng_start=1 from the cycle after the beat-44 handshake until eng_done is sampled 1.
  - On that edge: latch all 16 eng_res words internally, drop eng_start, go to DRAIN. out_valid=1 next cycle with word 0.
  - If eng_done is not seen within TIMEOUT cycles of entering START: err_timeout pulse, eng_start=0, go to ARM without producing output.
- DRAIN:
  - Standard valid/ready. Data and last are stable while out_valid&!out_ready. Words go in order c[0][0],c[0][1],...,c[3][3]; out_last=1 only on word 15.
  - The handshake on word 15 clears out_valid next cycle and goes to ARM.
- ARM: eng_arm_n=0 for exactly 2 cycles, then LOAD with in_ready=1.
- tile_o/kernel_o change only on accepted LOAD beats, so they are stable throughout START, DRAIN and ARM.
- busy=0 only when state==LOAD and beat counter==0.
- Results are passed through bit-exact: no saturation, no sign change.
- eng_done seen high in any state other than START is ignored.

Decomposition:
- Package conv_pkg: DATA_W, RES_W, TILE_DIM, KER_DIM, OUT_DIM constants; tile_t, kernel_t, result_t array typedefs; seq_state_e enum {LOAD, START, DRAIN, ARM}.
- Sub-module conv_result_serializer: takes a result_t plus load strobe and emits the 16-word valid/ready stream with out_last. It is reusable for other 4x4 producers.

Test Plan:
1. Kernel all 1, tile[r][c]=r*6+c, engine model asserts eng_done 20 cycles after eng_start -> kernel_o/tile_o match; eng_start rises 1 cycle after beat 44; 16 words c[0][0]=63 … c[3][3]=252 emitted in row-major order.
2. out_ready toggles 1,0,0,1 pattern -> out_data/out_last held while stalled; 16 words total, out_last only on word 15; then eng_arm_n low exactly 2 cycles and in_ready=1 after.
3. in_last on beat 10 -> err_len single pulse, in_ready stays 1; next clean 45-beat frame produces correct results.
4. eng_done tied 0 -> err_timeout pulses TIMEOUT cycles after START entry, out_valid never asserts, ARM pulse occurs, LOAD resumes.
5. rst_n asserted after 5 words drained -> all outputs immediately at reset values; next frame completes normally.
6. Engine model returns 0x8000 at c[0][0] and 0x7FFF at c[3][3], kernel bytes -128 -> out_data exactly 0x8000 and 0x7FFF, kernel_o[0][0]=-128.
